// File: rtl/sysctrl_gen.sv
// sysctrl_gen: MCU-facing system control block. Decodes the byte-serial MCU command stream into
// identification, LED/RGB, config register file, interrupt aggregation and byte-port traffic.
module sysctrl_gen #(
  parameter logic [7:0]           CORE_ID       = 8'h02,
  parameter int unsigned          NUM_CFG       = 32,
  parameter logic [7:0]           ID_BASE       = 8'h20,
  parameter logic [NUM_CFG*8-1:0] CFG_DEFAULTS  = {NUM_CFG{8'h00}},
  parameter int unsigned          INT_WIDTH     = 8,
  parameter int unsigned          RESET_TIMEOUT = 80_000_000,
  parameter int unsigned          LED_WIDTH     = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   data_in_strobe,
  input  logic                   data_in_start,
  input  logic [7:0]             data_in,
  output logic [7:0]             data_out,
  output logic                   int_out_n,
  input  logic [INT_WIDTH-1:0]   int_in,
  output logic [INT_WIDTH-1:0]   int_ack,
  input  logic [1:0]             buttons,
  output logic [LED_WIDTH-1:0]   leds,
  output logic [23:0]            color,
  output logic                   port_out_strobe,
  input  logic                   port_out_available,
  input  logic [7:0]             port_out_data,
  output logic                   port_in_strobe,
  output logic [7:0]             port_in_data,
  output logic [1:0]             system_reset,
  output logic [NUM_CFG*8-1:0]   cfg_bus,
  output logic [NUM_CFG-1:0]     cfg_strobe,
  output logic                   cold_boot
);

  localparam logic [7:0] CmdIdent   = 8'd0;
  localparam logic [7:0] CmdLeds    = 8'd1;
  localparam logic [7:0] CmdColor   = 8'd2;
  localparam logic [7:0] CmdButtons = 8'd3;
  localparam logic [7:0] CmdCfgWr   = 8'd4;
  localparam logic [7:0] CmdIntr    = 8'd5;
  localparam logic [7:0] CmdStatus  = 8'd6;
  localparam logic [7:0] CmdPortRd  = 8'd7;
  localparam logic [7:0] CmdPortWr  = 8'd8;
  localparam logic [7:0] CmdCfgRd   = 8'd9;
  localparam logic [7:0] CmdMask    = 8'd10;
  localparam logic [7:0] IdSysRst   = 8'h52;
  localparam int unsigned ToW  = (RESET_TIMEOUT > 1) ? $clog2(RESET_TIMEOUT + 1) : 1;
  localparam int unsigned IdxW = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1;

  function automatic logic [7:0] bit_rev(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  logic [7:0]             r_cmd, w_cmd_d;
  logic [3:0]             r_state, w_state_d;
  logic [7:0]             r_id, w_id_d;
  logic [7:0]             r_dout, w_dout_d;
  logic [LED_WIDTH-1:0]   r_leds, w_leds_d;
  logic [23:0]            r_color, w_color_d;
  logic [1:0]             r_sysrst, w_sysrst_d;
  logic [NUM_CFG*8-1:0]   r_cfg, w_cfg_d;
  logic [NUM_CFG-1:0]     r_cfg_strobe, w_cfg_strobe_d;
  logic [INT_WIDTH-1:0]   r_int_ack, w_int_ack_d;
  logic [7:0]             r_mask, w_mask_d;
  logic                   r_sys_int, w_sys_int_d;
  logic                   r_coldboot, w_coldboot_d;
  logic                   r_port_int, w_port_int_d;
  logic                   r_avail;
  logic [7:0]             r_pout_data, w_pout_data_d;
  logic                   r_pout_strobe, w_pout_strobe_d;
  logic [7:0]             r_pin_data, w_pin_data_d;
  logic                   r_pin_strobe, w_pin_strobe_d;
  logic [ToW-1:0]         r_timeout, w_timeout_d;

  logic [7:0]             w_index;
  logic                   w_in_range;
  int                     w_idx;
  logic [INT_WIDTH-1:0]   w_masked;
  logic [INT_WIDTH-1:0]   w_pend;

  // Wrapping subtraction maps ids below ID_BASE to large indices, so one compare covers both ends.
  assign w_index    = r_id - ID_BASE;
  assign w_in_range = 32'(w_index) < NUM_CFG;
  assign w_idx      = int'(w_index[IdxW-1:0]);
  assign w_masked   = int_in & r_mask[INT_WIDTH-1:0];
  assign w_pend     = w_masked | INT_WIDTH'(r_sys_int);

  always_comb begin
    w_cmd_d         = r_cmd;
    w_state_d       = r_state;
    w_id_d          = r_id;
    w_dout_d        = r_dout;
    w_leds_d        = r_leds;
    w_color_d       = r_color;
    w_sysrst_d      = r_sysrst;
    w_cfg_d         = r_cfg;
    w_cfg_strobe_d  = '0;
    w_int_ack_d     = '0;
    w_mask_d        = r_mask;
    w_sys_int_d     = r_sys_int & ~r_int_ack[0];
    w_coldboot_d    = r_coldboot;
    w_port_int_d    = r_port_int;
    w_pout_data_d   = r_pout_data;
    w_pout_strobe_d = 1'b0;
    w_pin_data_d    = r_pin_data;
    w_pin_strobe_d  = 1'b0;
    w_timeout_d     = r_timeout;

    if (r_timeout != '0) begin
      w_timeout_d = r_timeout - 1'b1;
      if (r_timeout == ToW'(1)) begin
        w_sysrst_d = 2'd0;
        w_color_d  = 24'h000202;
      end
    end

    if (data_in_strobe) begin
      if (data_in_start) begin
        w_cmd_d   = data_in;
        w_state_d = 4'd1;
      end else if (r_state != 4'd0) begin
        if (r_state != 4'd15) w_state_d = r_state + 4'd1;
        case (r_cmd)
          CmdIdent: begin
            case (r_state)
              4'd1:    w_dout_d = 8'h5C;
              4'd2:    w_dout_d = 8'h42;
              4'd3:    w_dout_d = CORE_ID;
              4'd4:    w_dout_d = 8'(NUM_CFG);
              default: ;
            endcase
          end
          CmdLeds: if (r_state == 4'd1) w_leds_d = data_in[LED_WIDTH-1:0];
          CmdColor: begin
            case (r_state)
              4'd1:    w_color_d[15:8]  = bit_rev(data_in);
              4'd2:    w_color_d[7:0]   = bit_rev(data_in);
              4'd3:    w_color_d[23:16] = bit_rev(data_in);
              default: ;
            endcase
          end
          CmdButtons: w_dout_d = {6'b0, buttons};
          CmdCfgWr: begin
            if (r_state == 4'd1) begin
              w_id_d = data_in;
            end else if (r_state == 4'd2) begin
              if (r_id == IdSysRst) begin
                w_sysrst_d  = data_in[1:0];
                w_timeout_d = '0;
              end else if (w_in_range) begin
                w_cfg_d[8*w_idx +: 8]   = data_in;
                w_cfg_strobe_d[w_idx]   = 1'b1;
              end
            end
          end
          CmdIntr: begin
            w_dout_d = 8'(w_pend);
            if (r_state == 4'd1) w_int_ack_d = data_in[INT_WIDTH-1:0];
          end
          CmdStatus: begin
            w_dout_d = {6'b0, r_port_int, r_coldboot};
            if (r_state == 4'd1) begin
              w_coldboot_d = 1'b0;
              w_port_int_d = 1'b0;
            end
          end
          CmdPortRd: begin
            if (r_state == 4'd1) begin
              w_dout_d        = {7'b0, port_out_available};
              w_pout_data_d   = port_out_data;
              w_pout_strobe_d = port_out_available;
            end else if (r_state == 4'd2) begin
              w_dout_d = r_pout_data;
            end
          end
          CmdPortWr: begin
            if (r_state == 4'd1) begin
              w_pin_data_d   = data_in;
              w_pin_strobe_d = 1'b1;
            end
          end
          CmdCfgRd: begin
            if (r_state == 4'd1) begin
              w_id_d = data_in;
            end else if (r_state == 4'd2) begin
              if (r_id == IdSysRst)  w_dout_d = {6'b0, r_sysrst};
              else if (w_in_range)   w_dout_d = r_cfg[8*w_idx +: 8];
              else                   w_dout_d = 8'h00;
            end
          end
          CmdMask: if (r_state == 4'd1) w_mask_d = data_in;
          default: ;
        endcase
      end
    end

    // Evaluated after the status clear so a coincident rising edge is not lost.
    if (port_out_available && !r_avail) w_port_int_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmd         <= 8'h00;
      r_state       <= 4'd0;
      r_id          <= 8'h00;
      r_dout        <= 8'h00;
      r_leds        <= '0;
      r_color       <= 24'h000000;
      r_sysrst      <= 2'd3;
      r_cfg         <= CFG_DEFAULTS;
      r_cfg_strobe  <= '0;
      r_int_ack     <= '0;
      r_mask        <= 8'hFF;
      r_sys_int     <= 1'b1;
      r_coldboot    <= 1'b1;
      r_port_int    <= 1'b0;
      r_avail       <= 1'b0;
      r_pout_data   <= 8'h00;
      r_pout_strobe <= 1'b0;
      r_pin_data    <= 8'h00;
      r_pin_strobe  <= 1'b0;
      r_timeout     <= ToW'(RESET_TIMEOUT);
    end else begin
      r_cmd         <= w_cmd_d;
      r_state       <= w_state_d;
      r_id          <= w_id_d;
      r_dout        <= w_dout_d;
      r_leds        <= w_leds_d;
      r_color       <= w_color_d;
      r_sysrst      <= w_sysrst_d;
      r_cfg         <= w_cfg_d;
      r_cfg_strobe  <= w_cfg_strobe_d;
      r_int_ack     <= w_int_ack_d;
      r_mask        <= w_mask_d;
      r_sys_int     <= w_sys_int_d;
      r_coldboot    <= w_coldboot_d;
      r_port_int    <= w_port_int_d;
      r_avail       <= port_out_available;
      r_pout_data   <= w_pout_data_d;
      r_pout_strobe <= w_pout_strobe_d;
      r_pin_data    <= w_pin_data_d;
      r_pin_strobe  <= w_pin_strobe_d;
      r_timeout     <= w_timeout_d;
    end
  end

  assign data_out        = r_dout;
  assign int_out_n       = ~((|w_masked) | r_sys_int | r_port_int);
  assign int_ack         = r_int_ack;
  assign leds            = r_leds;
  assign color           = r_color;
  assign port_out_strobe = r_pout_strobe;
  assign port_in_strobe  = r_pin_strobe;
  assign port_in_data    = r_pin_data;
  assign system_reset    = r_sysrst;
  assign cfg_bus         = r_cfg;
  assign cfg_strobe      = r_cfg_strobe;
  assign cold_boot       = r_coldboot;

endmodule

// File: tb/tb_sysctrl_gen.sv
// Self-checking bench for sysctrl_gen: scenario tasks driven by $urandom and checked against a
// behavioural model of the command set, config register file and interrupt state.
module tb_sysctrl_gen;
  localparam int unsigned NCFG = 32;
  localparam logic [7:0]  IDB  = 8'h20;

  function automatic logic [NCFG*8-1:0] mk_defaults();
    logic [NCFG*8-1:0] v;
    for (int i = 0; i < NCFG; i++) v[8*i +: 8] = 8'(i * 13 + 5);
    return v;
  endfunction

  logic clk, reset, data_in_strobe, data_in_start;
  logic [7:0] data_in, data_out, port_out_data, port_in_data;
  logic int_out_n, port_out_strobe, port_out_available, port_in_strobe, cold_boot;
  logic [7:0] int_in, int_ack;
  logic [1:0] buttons, leds, system_reset;
  logic [23:0] color;
  logic [NCFG*8-1:0] cfg_bus;
  logic [NCFG-1:0] cfg_strobe;

  sysctrl_gen #(.NUM_CFG(NCFG), .ID_BASE(IDB), .CFG_DEFAULTS(mk_defaults()),
                .RESET_TIMEOUT(100)) dut (
    .clk(clk), .reset(reset), .data_in_strobe(data_in_strobe), .data_in_start(data_in_start),
    .data_in(data_in), .data_out(data_out), .int_out_n(int_out_n), .int_in(int_in),
    .int_ack(int_ack), .buttons(buttons), .leds(leds), .color(color),
    .port_out_strobe(port_out_strobe), .port_out_available(port_out_available),
    .port_out_data(port_out_data), .port_in_strobe(port_in_strobe),
    .port_in_data(port_in_data), .system_reset(system_reset), .cfg_bus(cfg_bus),
    .cfg_strobe(cfg_strobe), .cold_boot(cold_boot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] m_cfg [NCFG];
  logic       m_sys;
  logic [1:0] m_sr;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = b[i];
    return r;
  endfunction

  function automatic logic [NCFG*8-1:0] cfg_flat();
    logic [NCFG*8-1:0] v;
    for (int i = 0; i < NCFG; i++) v[8*i +: 8] = m_cfg[i];
    return v;
  endfunction

  function automatic logic [7:0] cfg_expect(input logic [7:0] id);
    if (id == 8'h52) return {6'b0, m_sr};
    if (int'(id) >= int'(IDB) && int'(id) < int'(IDB) + NCFG) return m_cfg[int'(id) - int'(IDB)];
    return 8'h00;
  endfunction

  task automatic send(input logic st, input logic [7:0] d);
    @(negedge clk);
    data_in_strobe = 1'b1; data_in_start = st; data_in = d;
    @(negedge clk);
    data_in_strobe = 1'b0; data_in_start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; data_in_strobe = 0; data_in_start = 0; data_in = 0; int_in = 0; buttons = 0;
    port_out_available = 0; port_out_data = 0;
    for (int i = 0; i < NCFG; i++) m_cfg[i] = 8'(i * 13 + 5);
    m_sys = 1'b1; m_sr = 2'd3;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic cancel_timeout();
    send(1, 8'd4); send(0, 8'h52); send(0, 8'h00);
    m_sr = 2'd0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rst data_out got %h want 00", data_out); end
    checks++; if (color !== 24'h0 || leds !== 2'b0) begin errors++; $display("FAIL rst color/leds got %h/%b want 0", color, leds); end
    checks++; if (system_reset !== 2'd3) begin errors++; $display("FAIL rst system_reset got %0d want 3", system_reset); end
    checks++; if (cfg_bus !== cfg_flat()) begin errors++; $display("FAIL rst cfg_bus got %h want %h", cfg_bus, cfg_flat()); end
    checks++; if (cfg_strobe !== '0 || int_ack !== 8'h0 || port_out_strobe !== 0 || port_in_strobe !== 0) begin
      errors++; $display("FAIL rst pulses got %h %h %b %b want 0", cfg_strobe, int_ack, port_out_strobe, port_in_strobe); end
    checks++; if (cold_boot !== 1'b1 || int_out_n !== 1'b0) begin errors++; $display("FAIL rst coldboot/int_n got %b/%b want 1/0", cold_boot, int_out_n); end
  endtask

  task automatic test_ident();
    logic [7:0] exp [4];
    exp[0] = 8'h5C; exp[1] = 8'h42; exp[2] = 8'h02; exp[3] = 8'(NCFG);
    do_reset();
    send(1, 8'd0);
    for (int k = 0; k < 4; k++) begin
      send(0, 8'($urandom));
      checks++; if (data_out !== exp[k]) begin errors++; $display("FAIL ident byte%0d got %h want %h", k, data_out, exp[k]); end
    end
    send(1, 8'd5); send(0, 8'h01);
    checks++; if (int_ack !== 8'h01) begin errors++; $display("FAIL ident int_ack got %h want 01", int_ack); end
    @(negedge clk);
    checks++; if (int_ack !== 8'h00 || int_out_n !== 1'b1) begin errors++; $display("FAIL ident ack clear got %h/%b want 00/1", int_ack, int_out_n); end
  endtask

  task automatic test_cfg();
    logic [7:0] id, val;
    logic [NCFG-1:0] exp_s;
    do_reset(); cancel_timeout();
    send(1, 8'd4); send(0, 8'h23); send(0, 8'hA5); m_cfg[3] = 8'hA5;
    checks++; if (cfg_bus[31:24] !== 8'hA5 || cfg_strobe !== 32'h8) begin errors++; $display("FAIL cfg23 got %h/%h want A5/8", cfg_bus[31:24], cfg_strobe); end
    @(negedge clk);
    checks++; if (cfg_strobe !== '0) begin errors++; $display("FAIL cfg strobe width got %h want 0", cfg_strobe); end
    send(1, 8'd9); send(0, 8'h23); send(0, 8'h00);
    checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL cfg read23 got %h want A5", data_out); end
    send(1, 8'd4); send(0, 8'h7F); send(0, 8'h11);
    checks++; if (cfg_bus !== cfg_flat() || cfg_strobe !== '0) begin errors++; $display("FAIL cfg7F write got %h want unchanged", cfg_strobe); end
    send(1, 8'd9); send(0, 8'h7F); send(0, 8'h00);
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL cfg read7F got %h want 00", data_out); end
    for (int n = 0; n < 24; n++) begin
      id = 8'($urandom_range(int'(IDB) - 4, int'(IDB) + NCFG + 3)); val = 8'($urandom);
      exp_s = '0;
      if (int'(id) >= int'(IDB) && int'(id) < int'(IDB) + NCFG) begin
        m_cfg[int'(id) - int'(IDB)] = val; exp_s[int'(id) - int'(IDB)] = 1'b1;
      end
      send(1, 8'd4); send(0, id); send(0, val);
      checks++; if (cfg_bus !== cfg_flat() || cfg_strobe !== exp_s) begin
        errors++; $display("FAIL cfg rand id %h strobe got %h want %h", id, cfg_strobe, exp_s); end
      id = 8'($urandom_range(int'(IDB) - 4, int'(IDB) + NCFG + 3));
      send(1, 8'd9); send(0, id); send(0, 8'($urandom));
      checks++; if (data_out !== cfg_expect(id)) begin errors++; $display("FAIL cfg rd id %h got %h want %h", id, data_out, cfg_expect(id)); end
    end
    send(1, 8'd9); send(0, 8'h52); send(0, 8'h00);
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL cfg readR got %h want 00", data_out); end
  endtask

  task automatic test_timeout();
    do_reset();
    repeat (99) @(posedge clk);
    #1;
    checks++; if (system_reset !== 2'd3) begin errors++; $display("FAIL to cyc99 got %0d want 3", system_reset); end
    @(posedge clk); #1;
    checks++; if (system_reset !== 2'd0 || color !== 24'h000202) begin errors++; $display("FAIL to cyc100 got %0d/%h want 0/000202", system_reset, color); end
    do_reset();
    repeat (44) @(posedge clk);
    send(1, 8'd4); send(0, 8'h52);
    checks++; if (system_reset !== 2'd3) begin errors++; $display("FAIL to preR got %0d want 3", system_reset); end
    send(0, 8'h01); m_sr = 2'd1;
    checks++; if (system_reset !== 2'd1) begin errors++; $display("FAIL to R got %0d want 1", system_reset); end
    repeat (120) @(negedge clk);
    checks++; if (system_reset !== 2'd1 || color !== 24'h0) begin errors++; $display("FAIL to cancel got %0d/%h want 1/0", system_reset, color); end
    send(1, 8'd9); send(0, 8'h52); send(0, 8'h00);
    checks++; if (data_out !== cfg_expect(8'h52)) begin errors++; $display("FAIL to readR got %h want %h", data_out, cfg_expect(8'h52)); end
  endtask

  task automatic test_interrupts();
    logic [7:0] iv, mk, ak, pend;
    do_reset(); cancel_timeout();
    send(1, 8'd5); send(0, 8'h01); m_sys = 1'b0;
    @(negedge clk); int_in = 8'h04; @(negedge clk);
    checks++; if (int_out_n !== 1'b0) begin errors++; $display("FAIL irq 04 int_n got %b want 0", int_out_n); end
    send(1, 8'd10); send(0, 8'hFB);
    checks++; if (int_out_n !== 1'b1) begin errors++; $display("FAIL irq maskFB int_n got %b want 1", int_out_n); end
    send(1, 8'd5); send(0, 8'h00);
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL irq pend got %h want 00", data_out); end
    do_reset(); cancel_timeout();
    for (int n = 0; n < 16; n++) begin
      iv = 8'($urandom); mk = 8'($urandom); ak = 8'($urandom_range(0, 3));
      int_in = iv;
      send(1, 8'd10); send(0, mk);
      send(1, 8'd5); send(0, ak);
      pend = (iv & mk) | {7'b0, m_sys};
      checks++; if (data_out !== pend || int_ack !== ak) begin
        errors++; $display("FAIL irq rand pend/ack got %h/%h want %h/%h", data_out, int_ack, pend, ak); end
      if (ak[0]) m_sys = 1'b0;
      @(negedge clk);
      checks++; if (int_ack !== 8'h00 || int_out_n !== !(((iv & mk) != 0) || m_sys)) begin
        errors++; $display("FAIL irq rand int_n got %b/%h want %b/00", int_out_n, int_ack, !(((iv & mk) != 0) || m_sys)); end
    end
  endtask

  task automatic test_port();
    do_reset(); cancel_timeout();
    send(1, 8'd5); send(0, 8'h01); repeat (2) @(negedge clk);
    send(1, 8'd6); send(0, 8'h00);
    checks++; if (data_out !== 8'h01 || cold_boot !== 1'b0 || int_out_n !== 1'b1) begin
      errors++; $display("FAIL port st1 got %h/%b/%b want 01/0/1", data_out, cold_boot, int_out_n); end
    port_out_data = 8'h3C; port_out_available = 1'b1; @(negedge clk);
    checks++; if (int_out_n !== 1'b0) begin errors++; $display("FAIL port rise int_n got %b want 0", int_out_n); end
    send(1, 8'd6); send(0, 8'h00);
    checks++; if (data_out !== 8'h02 || int_out_n !== 1'b1) begin errors++; $display("FAIL port st2 got %h/%b want 02/1", data_out, int_out_n); end
    send(1, 8'd7); send(0, 8'h00);
    checks++; if (data_out !== 8'h01 || port_out_strobe !== 1'b1) begin errors++; $display("FAIL port rd1 got %h/%b want 01/1", data_out, port_out_strobe); end
    send(0, 8'h00);
    checks++; if (data_out !== 8'h3C || port_out_strobe !== 1'b0) begin errors++; $display("FAIL port rd2 got %h/%b want 3C/0", data_out, port_out_strobe); end
    port_out_available = 1'b0;
    send(1, 8'd7); send(0, 8'h00);
    checks++; if (data_out !== 8'h00 || port_out_strobe !== 1'b0) begin errors++; $display("FAIL port empty got %h/%b want 00/0", data_out, port_out_strobe); end
    send(1, 8'd6);
    @(negedge clk); data_in_strobe = 1; data_in = 8'h00; port_out_available = 1'b1;
    @(negedge clk); data_in_strobe = 0;
    checks++; if (data_out !== 8'h00 || int_out_n !== 1'b0) begin errors++; $display("FAIL port setwins got %h/%b want 00/0", data_out, int_out_n); end
    send(1, 8'd8); send(0, 8'h5A);
    checks++; if (port_in_data !== 8'h5A || port_in_strobe !== 1'b1) begin errors++; $display("FAIL port wr got %h/%b want 5A/1", port_in_data, port_in_strobe); end
    @(negedge clk);
    checks++; if (port_in_strobe !== 1'b0) begin errors++; $display("FAIL port wr pulse got %b want 0", port_in_strobe); end
  endtask

  task automatic test_color_leds();
    logic [7:0] b0, b1, b2;
    logic [23:0] ec;
    do_reset(); cancel_timeout();
    send(1, 8'd2); send(0, 8'h80); send(0, 8'h40); send(0, 8'h20);
    checks++; if (color !== 24'h040102) begin errors++; $display("FAIL color fixed got %h want 040102", color); end
    for (int n = 0; n < 6; n++) begin
      b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
      send(1, 8'd2); send(0, b0); send(0, b1); send(0, b2);
      ec = {rev8(b2), rev8(b0), rev8(b1)};
      checks++; if (color !== ec) begin errors++; $display("FAIL color rand got %h want %h", color, ec); end
      send(1, 8'd1); send(0, b0);
      checks++; if (leds !== b0[1:0]) begin errors++; $display("FAIL leds got %b want %b", leds, b0[1:0]); end
    end
    send(1, 8'd3);
    for (int n = 0; n < 20; n++) begin
      buttons = 2'($urandom); send(0, 8'($urandom));
      checks++; if (data_out !== {6'b0, buttons}) begin errors++; $display("FAIL buttons byte%0d got %h want %h", n, data_out, {6'b0, buttons}); end
    end
    send(1, 8'd2); send(0, 8'h80); ec = {ec[23:16], 8'h01, ec[7:0]};
    send(1, 8'd1); send(0, 8'h02);
    checks++; if (color !== ec || leds !== 2'd2) begin errors++; $display("FAIL abort got %h/%b want %h/10", color, leds, ec); end
    send(1, 8'd2); send(0, 8'hFF);
    #2 reset = 1'b1; #1;
    checks++; if (color !== 24'h0 || system_reset !== 2'd3 || leds !== 2'd0) begin
      errors++; $display("FAIL midreset got %h/%0d/%b want 000000/3/00", color, system_reset, leds); end
    @(negedge clk); reset = 1'b0;
    send(0, 8'h80);
    checks++; if (color !== 24'h0 || data_out !== 8'h00) begin errors++; $display("FAIL postreset payload got %h/%h want 0/0", color, data_out); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [4];
    exp[0] = 8'h5C; exp[1] = 8'h42; exp[2] = 8'h02; exp[3] = 8'(NCFG);
    do_reset(); cancel_timeout();
    @(negedge clk); data_in_strobe = 1; data_in_start = 1; data_in = 8'd0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); data_in_start = 0; data_in = 8'($urandom);
      if (k > 0) begin
        checks++; if (data_out !== exp[k-1]) begin errors++; $display("FAIL b2b ident%0d got %h want %h", k - 1, data_out, exp[k-1]); end
      end
    end
    @(negedge clk); data_in_strobe = 0;
    checks++; if (data_out !== exp[3]) begin errors++; $display("FAIL b2b ident3 got %h want %h", data_out, exp[3]); end
    @(negedge clk); data_in_strobe = 1; data_in_start = 1; data_in = 8'd4;
    @(negedge clk); data_in_start = 0; data_in = 8'h25;
    @(negedge clk); data_in = 8'h3E;
    @(negedge clk); data_in_strobe = 0; m_cfg[5] = 8'h3E;
    checks++; if (cfg_strobe !== 32'h20 || cfg_bus !== cfg_flat()) begin errors++; $display("FAIL b2b cfg got %h want 20", cfg_strobe); end
    @(negedge clk);
    checks++; if (cfg_strobe !== '0) begin errors++; $display("FAIL b2b cfg pulse got %h want 0", cfg_strobe); end
  endtask

  initial begin
    reset = 1'b1; data_in_strobe = 0; data_in_start = 0; data_in = 0; int_in = 0; buttons = 0;
    port_out_available = 0; port_out_data = 0;
    test_reset();
    test_ident();
    test_cfg();
    test_timeout();
    test_interrupts();
    test_port();
    test_color_leds();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
